i2c_ccd_target: RTL
===================

Name: i2c_ccd_target

Overview:
- Synthesizable I2C target (responder) that emulates the CCD sensor's register interface on the shared I2C_SCLK/I2C_SDAT bus.
- Answers the config master's writes: slave byte, sub-address byte, then data bytes. Also supports reads via repeated START.
- Lets camera-path logic and benches run without a physical sensor.
- Stores registers internally, exposes a host read port, and pulses a strobe on every committed write.

Parameters:
- SLAVE_ADDR, 7'h5D, 7-bit target address (write byte 8'hBA, read byte 8'hBB).
- REG_AW, 5, register-file address width; 2**REG_AW 8-bit registers.
- RST_VAL, 8'h00, reset value of every register.

Ports:
- iCLK  input  1  system clock, 50 MHz; must be ≥16x the SCL rate.
- iRST_N  input  1  asynchronous active-low reset.
- I2C_SCLK  input  1  I2C clock from the master.
- I2C_SDAT  inout  1  I2C data, open-drain; the block drives only 0 or Z.
- iRD_ADDR  input  REG_AW  host read address.
- oRD_DATA  output  8  register[iRD_ADDR], combinational.
- oWR_STB  output  1  one-cycle pulse per committed write byte.
- oWR_ADDR  output  REG_AW  register written; valid with oWR_STB, held until the next write.
- oWR_DATA  output  8  byte written; valid with oWR_STB, held until the next write.
- oBUSY  output  1  high from an address match until STOP, NACK or mismatch.

Behaviour:
- Reset (async, iRST_N low):
  - all registers = RST_VAL; sub-address pointer = 0; state IDLE; SDA released (Z).
  - oWR_STB=0, oWR_ADDR=0, oWR_DATA=0, oBUSY=0.
- Input conditioning: SCL and SDA each go through a 2-FF synchronizer into iCLK, plus a previous-value register for edge detection.
- Bus events, judged on synchronized signals:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
- SDA sampling and driving:
  - Data bits are sampled on the synchronized SCL rising edge, MSB first.
  - The block changes its SDA drive only on the synchronized SCL falling edge, 3 iCLK after the pin edge.
- A 4-bit bit counter counts 0..8; slot 8 is the ACK slot.
- State machine:
  - IDLE: ignore the bus; START -> ADDR.
  - ADDR: shift in 8 bits.
    - Bits[7:1]==SLAVE_ADDR: ACK (drive 0 through slot 8), set oBUSY; R/W=0 -> SUB, R/W=1 -> RDATA.
    - Mismatch: leave SDA released (NACK) -> IDLE.
  - SUB: shift in the sub-address byte, load the pointer, ACK -> WDATA.
  - WDATA: shift in a byte, ACK.
    - On the rising SCL edge of bit 7, if pointer[7:REG_AW]==0: write register[pointer[REG_AW-1:0]] and pulse oWR_STB with oWR_ADDR/oWR_DATA.
    - Otherwise discard the byte but still ACK.
    - Pointer increments (8-bit, wraps 8'hFF -> 8'h00) after every data byte. Stay in WDATA.
  - RDATA: drive register[pointer] MSB first.
    - Drive starts on the SCL falling edge that ends the preceding ACK slot.
    - Drive 0 for 0-bits, Z for 1-bits. An out-of-range pointer reads 8'h00.
    - Release SDA for slot 8 and sample the master's ACK; pointer += 1.
    - ACK (0): next byte. NACK (1): clear oBUSY -> IDLE.
- Repeated START in any state: release SDA, clear the bit counter -> ADDR; the pointer is retained. This supports the write-sub-address then read sequence.
- STOP in any state: release SDA, clear oBUSY -> IDLE; the pointer is retained.
- A START or STOP seen mid-byte aborts the byte; partially received WDATA bits are never written.
- Simultaneous host read and I2C write to the same register: oRD_DATA shows the old value that cycle and the new value the next cycle.
- Reset mid-transfer: SDA is released immediately and asynchronously, and the state returns to IDLE.

Test Plan:
- Write 8'hBA, 8'h05, 8'h88, STOP -> all three bytes ACKed; one oWR_STB with oWR_ADDR=5, oWR_DATA=8'h88; then iRD_ADDR=5 gives oRD_DATA=8'h88.
- Burst write 8'hBA, 8'h1E, 8'hAA, 8'hBB, 8'hCC -> writes reg30=AA, reg31=BB. The third byte goes to pointer 8'h20, which is out of range: it is ACKed, no strobe. Exactly two oWR_STB pulses.
- Write 8'hBA, 8'h02, repeated START, 8'hBB, read two bytes (master ACK, then NACK) with reg2=8'h11 and reg3=8'h22 -> SDA returns 8'h11 then 8'h22; after the NACK, SDA is Z and oBUSY=0.
- Address 8'hB8 followed by data bytes -> no ACK, SDA never driven, no oWR_STB, oBUSY stays 0.
- STOP after 4 data bits of a WDATA byte, then a new write 8'hBA, 8'h07, 8'h5A -> the aborted byte is not written; reg7=8'h5A.
- iRST_N low while the block is driving ACK -> SDA Z within the reset assertion; all outputs at reset values; a subsequent normal write succeeds.

Source files
------------

// File: rtl/i2c_ccd_target_if.sv
// ---------------------------------------------------------------------------
// i2c_ccd_target_if
// Host-side port bundle of the emulated CCD sensor's register interface.
//   iRD_ADDR  host read address into the register file
//   oRD_DATA  register[iRD_ADDR], combinational
//   oWR_STB   one-cycle pulse per committed I2C write byte
//   oWR_ADDR  register index of the last committed write
//   oWR_DATA  data byte of the last committed write
//   oBUSY     high while an addressed transfer is in progress
// The target drives the 'slave' modport; the host/camera logic uses 'master'.
// ---------------------------------------------------------------------------
interface i2c_ccd_target_if #(
    parameter int REG_AW = 5
) ();
    logic [REG_AW-1:0] iRD_ADDR;
    logic [7:0]        oRD_DATA;
    logic              oWR_STB;
    logic [REG_AW-1:0] oWR_ADDR;
    logic [7:0]        oWR_DATA;
    logic              oBUSY;

    modport slave (
        input  iRD_ADDR,
        output oRD_DATA,
        output oWR_STB,
        output oWR_ADDR,
        output oWR_DATA,
        output oBUSY
    );

    modport master (
        output iRD_ADDR,
        input  oRD_DATA,
        input  oWR_STB,
        input  oWR_ADDR,
        input  oWR_DATA,
        input  oBUSY
    );
endinterface

// File: rtl/i2c_ccd_target.sv
// ---------------------------------------------------------------------------
// i2c_ccd_target
// I2C target that stands in for the CCD sensor's register interface so that
// the config master and camera path can run without the physical sensor.
// Accepts  START, addr+W, sub-address, data...  and reads through a repeated
// START with addr+R. Registers live in an internal 2**REG_AW x 8 file.
//   iCLK      system clock (>= 16x SCL rate)
//   iRST_N    asynchronous active-low reset
//   I2C_SCLK  bus clock from the master
//   I2C_SDAT  open-drain bus data; only 0 or Z is ever driven
//   host      register read port, write strobe/echo and busy flag
// ---------------------------------------------------------------------------
module i2c_ccd_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h5D,
    parameter int         REG_AW     = 5,
    parameter logic [7:0] RST_VAL    = 8'h00
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  I2C_SCLK,
    inout  wire                   I2C_SDAT,
    i2c_ccd_target_if.slave       host
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SUB,
        WDATA,
        RDATA
    } state_t;

    localparam int NREGS = 2 ** REG_AW;

    logic [7:0]        regs_q [NREGS];

    logic              scl_s1_q, scl_s2_q, scl_prev_q;
    logic              sda_s1_q, sda_s2_q, sda_prev_q;

    state_t            state_q,   state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              in_ack_q,  in_ack_d;
    logic [7:0]        shreg_q,   shreg_d;
    logic [7:0]        ptr_q,     ptr_d;
    logic [7:0]        tx_q,      tx_d;
    logic              rw_q,      rw_d;
    logic              mack_q,    mack_d;
    logic              sda_oe_q,  sda_oe_d;
    logic              busy_q,    busy_d;
    logic              wr_stb_q,  wr_stb_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic              scl_rise, scl_fall, start_det, stop_det;
    logic              in_range;
    logic [7:0]        rd_byte;
    logic [7:0]        rx_byte;

    // Both bus lines are brought into iCLK through two flops; the third flop
    // holds the previous synchronized value for edge detection. They reset to
    // the idle-high bus level so reset release never looks like a bus event.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= I2C_SCLK;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= I2C_SDAT;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    assign scl_rise  =  scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q &  scl_prev_q;
    assign start_det =  scl_s2_q & ~sda_s2_q &  sda_prev_q;
    assign stop_det  =  scl_s2_q &  sda_s2_q & ~sda_prev_q;

    // Pointer bits above the register-file width must be zero for a real
    // register; anything beyond reads as zero and swallows writes.
    assign in_range = ((ptr_q >> REG_AW) == 8'd0);
    assign rd_byte  = in_range ? regs_q[ptr_q[REG_AW-1:0]] : 8'h00;
    assign rx_byte  = {shreg_q[6:0], sda_s2_q};

    // Protocol FSM. Bits are taken on SCL rise; all SDA drive changes happen
    // on SCL fall. After the 8th rise (bit_cnt==8) the next fall opens the
    // ACK slot (in_ack), and the fall after that closes it and moves on.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        in_ack_d  = in_ack_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            in_ack_d  = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            in_ack_d  = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (state_q != IDLE) begin
            if (scl_rise) begin
                if (in_ack_q) begin
                    if (state_q == RDATA) begin
                        mack_d = sda_s2_q;
                    end
                end else if (bit_cnt_q < 4'd8) begin
                    shreg_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // The write commits on the last data bit, so a byte cut
                    // short by START/STOP never reaches the register file.
                    if (state_q == WDATA && bit_cnt_q == 4'd7 && in_range) begin
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q[REG_AW-1:0];
                        wr_data_d = rx_byte;
                    end
                end
            end else if (scl_fall) begin
                if (!in_ack_q && bit_cnt_q == 4'd8) begin
                    in_ack_d = 1'b1;
                    case (state_q)
                        ADDR: begin
                            if (shreg_q[7:1] == SLAVE_ADDR) begin
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shreg_q[0];
                            end else begin
                                state_d   = IDLE;
                                bit_cnt_d = 4'd0;
                                in_ack_d  = 1'b0;
                                sda_oe_d  = 1'b0;
                                busy_d    = 1'b0;
                            end
                        end
                        SUB: begin
                            ptr_d    = shreg_q;
                            sda_oe_d = 1'b1;
                        end
                        WDATA: begin
                            ptr_d    = ptr_q + 8'd1;
                            sda_oe_d = 1'b1;
                        end
                        RDATA: begin
                            ptr_d    = ptr_q + 8'd1;
                            sda_oe_d = 1'b0;
                        end
                        default: ;
                    endcase
                end else if (in_ack_q) begin
                    in_ack_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    sda_oe_d  = 1'b0;
                    case (state_q)
                        ADDR: begin
                            if (rw_q) begin
                                state_d  = RDATA;
                                tx_d     = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                            end else begin
                                state_d = SUB;
                            end
                        end
                        SUB:   state_d = WDATA;
                        RDATA: begin
                            if (!mack_q) begin
                                tx_d     = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end else if (state_q == RDATA) begin
                    // bit_cnt bits already sent; present bit 7-bit_cnt next.
                    sda_oe_d = ~tx_q[~bit_cnt_q[2:0]];
                end
            end
        end
    end

    // FSM and datapath state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            in_ack_q  <= 1'b0;
            shreg_q   <= 8'h00;
            ptr_q     <= 8'h00;
            tx_q      <= 8'h00;
            rw_q      <= 1'b0;
            mack_q    <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            in_ack_q  <= in_ack_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file; updated on the same edge the write strobe rises, so a
    // host read of that register sees the new value from the next cycle on.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else if (wr_stb_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    // Open drain: pull low or let go. sda_oe_q resets asynchronously, so the
    // line is released the moment reset asserts.
    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

    assign host.oRD_DATA = regs_q[host.iRD_ADDR];
    assign host.oWR_STB  = wr_stb_q;
    assign host.oWR_ADDR = wr_addr_q;
    assign host.oWR_DATA = wr_data_q;
    assign host.oBUSY    = busy_q;

endmodule
